vga_sync_rx: RTL and testbench

//  Receive-side counterpart of the VGA timing generator (vdt) and renderer.

---
 rtl/vga_sync_rx_if.sv | 19 +
 rtl/vga_sync_rx.sv | 105 ++++++++++
 tb/tb_vga_sync_rx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/vga_sync_rx_if.sv
// vga_sync_rx_if: display stream (hs/vs/prgb) into the monitor, recovered timing and pixel status out.
interface vga_sync_rx_if;
  logic        hs;
  logic        vs;
  logic [11:0] prgb;
  logic [10:0] x_rec;
  logic [9:0]  y_rec;
  logic        de;
  logic [11:0] pix_out;
  logic        locked;
  logic        frame_done;
  logic        err;
  logic [7:0]  err_cnt;
  logic [15:0] frame_sum;
  modport master (output hs, vs, prgb,
                  input x_rec, y_rec, de, pix_out, locked, frame_done, err, err_cnt, frame_sum);
  modport slave (input hs, vs, prgb,
                 output x_rec, y_rec, de, pix_out, locked, frame_done, err, err_cnt, frame_sum);
endinterface

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: locks to the VGA stream timing, recovers x/y and active-window pixels, flags violations.
// Define FRAME_SUM_EN to build the per-frame active-pixel checksum on frame_sum.
module vga_sync_rx #(
  parameter int H_TOTAL     = 1040,
  parameter int V_TOTAL     = 666,
  parameter int HSW         = 120,
  parameter int LEFT_BOUND  = 184,
  parameter int RIGHT_BOUND = 983,
  parameter int UP_BOUND    = 29,
  parameter int DOWN_BOUND  = 628
) (
  input logic         pclk,
  input logic         rst,
  vga_sync_rx_if.slave io
);
  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;
  state_t      state, state_n;
  logic        ok, ok_n;
  logic        hs_q, vs_q;
  logic [10:0] hc, hc_n;
  logic [9:0]  vc, vc_n;
  logic        hs_rise, hs_fall, vs_rise, viol;
  logic        err_n, fd_n, de_n;
  assign hs_rise = io.hs & ~hs_q;
  assign hs_fall = ~io.hs & hs_q;
  assign vs_rise = io.vs & ~vs_q;
  assign hc_n = hs_rise ? 11'd0 : hc == 11'h7ff ? hc : hc + 11'd1;
  assign vc_n = hs_rise & vs_rise ? 10'd0 : hs_rise & vc != 10'h3ff ? vc + 10'd1 : vc;
  // hc/vc hold the coordinates of the previous sample, so the checks compare against "last x/y"
  assign viol = (hs_rise & hc != 11'(H_TOTAL - 1))
              | (hs_fall & hc != 11'(HSW - 1))
              | (~hs_rise & hc == 11'(H_TOTAL - 1))
              | (vs_rise & (vc != 10'(V_TOTAL - 1) | ~hs_rise));
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      state <= SEARCH;
      ok    <= 1'b0;
    end else begin
      state <= state_n;
      ok    <= ok_n;
    end
  // ok tracks whether the ALIGN frame measured so far has been clean
  always_comb begin
    state_n = state;
    ok_n    = ok;
    case (state)
      SEARCH: if (vs_rise) begin
        state_n = ALIGN;
        ok_n    = 1'b1;
      end
      ALIGN: if (vs_rise) begin
        state_n = ok & ~viol ? LOCKED : ALIGN;
        ok_n    = 1'b1;
      end else if (viol) ok_n = 1'b0;
      LOCKED: if (viol) state_n = SEARCH;
      default: state_n = SEARCH;
    endcase
  end
  always_comb begin
    err_n = state == LOCKED & viol;
    fd_n  = state == LOCKED & vs_rise & ~viol;
    de_n  = state_n == LOCKED
          & hc_n >= 11'(LEFT_BOUND) & hc_n <= 11'(RIGHT_BOUND)
          & vc_n >= 10'(UP_BOUND) & vc_n <= 10'(DOWN_BOUND);
  end
  assign io.locked = state == LOCKED;
  assign io.x_rec  = hc;
  assign io.y_rec  = vc;
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      hc            <= '0;
      vc            <= '0;
      io.de         <= 1'b0;
      io.pix_out    <= '0;
      io.err        <= 1'b0;
      io.frame_done <= 1'b0;
      io.err_cnt    <= '0;
    end else begin
      hs_q          <= io.hs;
      vs_q          <= io.vs;
      hc            <= hc_n;
      vc            <= vc_n;
      io.de         <= de_n;
      io.pix_out    <= de_n ? io.prgb : 12'h000;
      io.err        <= err_n;
      io.frame_done <= fd_n;
      io.err_cnt    <= io.err_cnt + {7'd0, err_n & io.err_cnt != 8'hff};
    end
`ifdef FRAME_SUM_EN
  logic [15:0] acc;
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      acc          <= '0;
      io.frame_sum <= '0;
    end else if (io.frame_done) begin
      io.frame_sum <= acc;
      acc          <= '0;
    end else if (!io.locked) acc <= '0;
    else if (io.de) acc <= acc + {4'h0, io.pix_out};
`else
  assign io.frame_sum = 16'h0000;
`endif
endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: directed bench for vga_sync_rx on a shrunken 10x6 raster so many frames fit in a short run.
module tb_vga_sync_rx;
  localparam int H = 10, V = 6, HS = 2, VS = 2;
  logic pclk = 1'b0;
  logic rst  = 1'b1;
  vga_sync_rx_if bus();
  vga_sync_rx #(.H_TOTAL(H), .V_TOTAL(V), .HSW(HS), .LEFT_BOUND(3), .RIGHT_BOUND(8),
                .UP_BOUND(2), .DOWN_BOUND(4)) dut (.pclk(pclk), .rst(rst), .io(bus));
  always #5 pclk = ~pclk;
  typedef struct {int x; int y; logic de; logic [11:0] pix;} vec_t;
  vec_t tbl[11];
  int checks = 0, errors = 0;
  int gx = 0, gy = 0, lx = 0, ly = 0;
  logic hs_force = 1'b0;
  logic [15:0] exp_sum;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // one generator sample; outputs are read 1 time unit after the edge that captured it
  task automatic step();
    bus.hs   = (gx < HS) | hs_force;
    bus.vs   = gy < VS;
    bus.prgb = 12'(gx * 16 + gy);
    lx = gx;
    ly = gy;
    @(posedge pclk);
    #1;
    gx++;
    if (gx == H) begin
      gx = 0;
      gy = (gy + 1) % V;
    end
  endtask
  task automatic goto(input int x, input int y);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(lx == x && ly == y) && n < 2 * H * V);
    chk("goto", {31'd0, lx == x && ly == y}, 1);
  endtask
  task automatic shorten_line();
    goto(H - 2, 2);
    gx = 0;
    gy = 3;
    step();
  endtask
  task automatic wait_lock();
    int n = 0;
    while (!bus.locked && n < 4 * H * V) begin
      step();
      n++;
    end
    chk("lock_wait", bus.locked, 1);
  endtask
  initial begin
    tbl[0]  = '{3, 1, 1'b0, 12'h000};
    tbl[1]  = '{2, 2, 1'b0, 12'h000};
    tbl[2]  = '{3, 2, 1'b1, 12'h032};
    tbl[3]  = '{8, 2, 1'b1, 12'h082};
    tbl[4]  = '{9, 2, 1'b0, 12'h000};
    tbl[5]  = '{5, 3, 1'b1, 12'h053};
    tbl[6]  = '{3, 4, 1'b1, 12'h034};
    tbl[7]  = '{8, 4, 1'b1, 12'h084};
    tbl[8]  = '{9, 4, 1'b0, 12'h000};
    tbl[9]  = '{3, 5, 1'b0, 12'h000};
    tbl[10] = '{0, 0, 1'b0, 12'h000};
`ifdef FRAME_SUM_EN
    exp_sum = 16'd1638;
`else
    exp_sum = 16'd0;
`endif
    bus.hs = 1'b1;
    bus.vs = 1'b1;
    bus.prgb = '0;
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_locked", bus.locked, 0);
    chk("rst_de", bus.de, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    chk("rst_xy", {bus.x_rec, bus.y_rec}, 0);
    chk("rst_sum", bus.frame_sum, 0);
    rst = 1'b0;
    step();
    goto(0, 0);
    chk("align_not_locked", bus.locked, 0);
    goto(0, 0);
    chk("locked_2nd_vs", bus.locked, 1);
    chk("no_fd_on_lock", bus.frame_done, 0);
    goto(0, 0);
    chk("fd_3rd_vs", bus.frame_done, 1);
    chk("err_cnt_clean", bus.err_cnt, 0);
    step();
    chk("fd_one_cycle", bus.frame_done, 0);
    chk("frame_sum", bus.frame_sum, {16'd0, exp_sum});
    for (int i = 0; i < 11; i++) begin
      goto(tbl[i].x, tbl[i].y);
      chk($sformatf("de[%0d]", i), bus.de, tbl[i].de);
      chk($sformatf("pix[%0d]", i), bus.pix_out, tbl[i].pix);
      chk($sformatf("x_rec[%0d]", i), bus.x_rec, tbl[i].x);
      chk($sformatf("y_rec[%0d]", i), bus.y_rec, tbl[i].y);
    end
    shorten_line();
    chk("short_err", bus.err, 1);
    chk("short_err_cnt", bus.err_cnt, 1);
    chk("short_unlock", bus.locked, 0);
    step();
    chk("err_one_cycle", bus.err, 0);
    goto(0, 0);
    chk("relock_align", bus.locked, 0);
    goto(0, 0);
    chk("relock", bus.locked, 1);
    goto(HS - 1, 2);
    hs_force = 1'b1;
    step();
    hs_force = 1'b0;
    chk("wide_hs_pending", bus.err, 0);
    step();
    chk("wide_hs_err", bus.err, 1);
    chk("wide_hs_cnt", bus.err_cnt, 2);
    chk("wide_hs_unlock", bus.locked, 0);
    for (int k = 0; k < 298; k++) begin
      wait_lock();
      if (!bus.locked) break;
      shorten_line();
    end
    chk("err_cnt_sat", bus.err_cnt, 255);
    wait_lock();
    goto(5, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_locked", bus.locked, 0);
    chk("mid_rst_err_cnt", bus.err_cnt, 0);
    chk("mid_rst_outs", {bus.de, bus.pix_out, bus.err, bus.frame_done, bus.x_rec, bus.y_rec}, 0);
    step();
    rst = 1'b0;
    goto(0, 0);
    chk("post_rst_align", bus.locked, 0);
    goto(0, 0);
    chk("post_rst_lock", bus.locked, 1);
    chk("post_rst_err_cnt", bus.err_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
